spi_slave_ram_if: RTL and testbench
===================================

# spi_slave_ram_if

Serial front end that drives the single-port RAM's 10-bit command/data interface. It deserializes SPI frames on MOSI into `rx_data`/`rx_valid` words, the format the RAM consumes. For read-data commands it captures the RAM's `tx_data`/`tx_valid` reply and shifts it out on MISO. It sits between the chip-level SPI pins and the RAM, on the same clock.

## Interface
- `ADDR_SIZE`, default 8: RAM address/data width. The command word is `ADDR_SIZE+2` bits.
- `clk` input 1: system clock. All sampling is on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `MOSI` input 1: serial data in, MSB first.
- `SS_n` input 1: active-low frame select.
- `MISO` output 1: serial data out, MSB first.
- `rx_data` output `ADDR_SIZE+2`: command word to the RAM. Bits [9:8] are the opcode: 00 write address, 01 write data, 10 read address, 11 read data.
- `rx_valid` output 1: one-cycle strobe qualifying `rx_data`.
- `tx_data` input `ADDR_SIZE`: read data from the RAM.
- `tx_valid` input 1: qualifies `tx_data`.
- `frame_err` output 1: present only with `SPI_FRAME_ERR_EN`.

## Operation
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: `SS_n`=0 → CHK_CMD.
- CHK_CMD: samples MOSI as bit 9.
  - Bit 9 = 0 → WRITE.
  - Bit 9 = 1 and `rd_addr_seen`=0 → READ_ADD.
  - Bit 9 = 1 and `rd_addr_seen`=1 → READ_DATA.
- Frame capture: a 4-bit counter collects bits 9..0. When bit 0 is captured, `rx_data` is loaded and `rx_valid` fires once per frame.
- Extra MOSI bits after bit 0 are ignored until `SS_n` returns high.
- `rd_addr_seen`:
  - set when a READ_ADD frame completes;
  - cleared when a READ_DATA frame completes;
  - unchanged by WRITE frames.
- READ_DATA, after `rx_valid`:
  - waits for `tx_valid`=1 and latches `tx_data` into an 8-bit shift register;
  - drives MISO from that register, MSB first, one bit per cycle;
  - drives MISO=0 after all 8 bits are sent.
- `tx_valid` is ignored in every state except READ_DATA awaiting the reply.
- `SS_n`=1 in any state → IDLE next cycle:
  - counter cleared;
  - MISO=0;
  - no `rx_valid` for an incomplete frame;
  - `rd_addr_seen` unchanged.

## Timing
- Reset values: `MISO`=0, `rx_data`=0, `rx_valid`=0, `frame_err`=0, state IDLE, `rd_addr_seen`=0, counter 0.
- Edge 0: `SS_n` sampled low in IDLE.
- Edges 1..10: bits 9..0 sampled.
- `rx_valid` and `rx_data` are registered at edge 10 and are valid for the cycle after edge 10.
- `rx_data` holds its value until the next frame completes.
- Read data:
  - `tx_valid` sampled high at edge T → MISO = `tx_data[7]` after edge T;
  - `tx_data[0]` is driven after edge T+7;
  - MISO=0 after edge T+8.
- `SS_n` high and low on consecutive edges starts a fresh frame, with CHK_CMD on the second edge.

## Configuration
- Macro `SPI_FRAME_ERR_EN`.
- Defined:
  - adds the `frame_err` output;
  - `frame_err` is a one-cycle pulse when `SS_n` rises with 1–9 bits captured, or during READ_DATA before all 8 MISO bits are sent.
- Undefined: no port and no logic; aborts are silent.

## Structure
- Shared package `spi_pkg` holds:
  - state enum `spi_state_e`;
  - opcode constants `OP_WR_ADDR`=2'b00, `OP_WR_DATA`=2'b01, `OP_RD_ADDR`=2'b10, `OP_RD_DATA`=2'b11.
- One sub-module, `spi_shift_out`: 8-bit parallel-load, MSB-first serializer with a done flag, used for MISO.

## Test plan
- Write frame 0x0A5 (00_1010_0101) → one `rx_valid` pulse, `rx_data`=10'h0A5, MISO stays 0, `rd_addr_seen` stays 0.
- Read-address frame 10'h2A5 → `rx_data`=10'h2A5. The next frame 10'h3xx enters READ_DATA. The RAM stub returns `tx_valid` with 8'hC3 → MISO emits 1,1,0,0,0,0,1,1 on consecutive cycles, then 0.
- Read data without a prior read address → frame starting with bit 1 is routed to READ_ADD; `rd_addr_seen`=1 afterwards.
- `SS_n` raised after 5 bits → no `rx_valid`, FSM in IDLE next cycle. With `SPI_FRAME_ERR_EN` defined, `frame_err` pulses once.
- `rst_n` asserted mid-READ_DATA shift → MISO=0 and state IDLE immediately; `rd_addr_seen`=0 after release.
- 14 MOSI bits in one frame → exactly one `rx_valid`, carrying the first 10 bits.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end of the single-port RAM.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } spi_state_e;

    // Opcode carried in the top two bits of the command word.
    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_shift_out.sv
// Parallel-load, MSB-first serializer for MISO. Output is 0 whenever idle;
// done goes high once the last bit has been shifted out and stays high until
// the next load or clear.
module spi_shift_out #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic             miso,
    output logic             done
);

    localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] sreg_q;
    logic [IdxW-1:0]  idx_q;
    logic             busy_q;
    logic             done_q;

    // Load, then shift left one bit per cycle until the LSB has been presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
            idx_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (clr) begin
            sreg_q <= '0;
            idx_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (load) begin
            sreg_q <= data;
            idx_q  <= IdxW'(WIDTH - 1);
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (busy_q) begin
            if (idx_q == '0) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end else begin
                sreg_q <= sreg_q << 1;
                idx_q  <= idx_q - 1'b1;
            end
        end
    end

    assign miso = busy_q & sreg_q[WIDTH-1];
    assign done = done_q;

endmodule

// File: rtl/spi_slave_ram_if.sv
// SPI slave front end for the single-port RAM: deserializes MOSI frames into
// rx_data/rx_valid command words and serializes the RAM read reply on MISO.
// Optional feature macro: SPI_FRAME_ERR_EN adds the frame_err abort pulse.
module spi_slave_ram_if
    import spi_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 MOSI,
    input  logic                 SS_n,
    output logic                 MISO,
    output logic [ADDR_SIZE+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] tx_data,
    input  logic                 tx_valid
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic                 frame_err
`endif
);

    localparam int unsigned WordW = ADDR_SIZE + 2;
    localparam int unsigned CntW  = $clog2(WordW + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WordW - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(WordW);

    spi_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q;
    logic [WordW-1:0] shift_q;
    logic [WordW-1:0] rx_data_q;
    logic             rx_valid_q;
    logic             rd_addr_seen_q;
    logic             reply_taken_q;
    logic             in_frame;
    logic             capture;
    logic             last_bit;
    logic             tx_load;
    logic             tx_done;

    assign in_frame = (state_q == WRITE) || (state_q == READ_ADD) || (state_q == READ_DATA);
    // Bits are taken in CHK_CMD (bit 9) and in the data states until the word is full.
    assign capture  = !SS_n && ((state_q == CHK_CMD) || (in_frame && (cnt_q != CntFull)));
    assign last_bit = capture && in_frame && (cnt_q == CntLast);
    // Only the first tx_valid after a completed read-data frame is accepted.
    assign tx_load  = !SS_n && (state_q == READ_DATA) && (cnt_q == CntFull) && !reply_taken_q
                      && tx_valid;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: SS_n high aborts to IDLE from anywhere; the command bit picks the path.
    always_comb begin
        state_d = state_q;
        if (SS_n) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = CHK_CMD;
                CHK_CMD: begin
                    if (!MOSI) begin
                        state_d = WRITE;
                    end else if (rd_addr_seen_q) begin
                        state_d = READ_DATA;
                    end else begin
                        state_d = READ_ADD;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Frame capture, command word output and read-address tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            shift_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            reply_taken_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (SS_n) begin
                cnt_q         <= '0;
                reply_taken_q <= 1'b0;
            end else begin
                if (capture) begin
                    shift_q <= {shift_q[WordW-2:0], MOSI};
                    cnt_q   <= cnt_q + 1'b1;
                end
                if (last_bit) begin
                    rx_data_q  <= {shift_q[WordW-2:0], MOSI};
                    rx_valid_q <= 1'b1;
                    if (state_q == READ_ADD) begin
                        rd_addr_seen_q <= 1'b1;
                    end else if (state_q == READ_DATA) begin
                        rd_addr_seen_q <= 1'b0;
                    end
                end
                if (tx_load) begin
                    reply_taken_q <= 1'b1;
                end
            end
        end
    end

    spi_shift_out #(
        .WIDTH(ADDR_SIZE)
    ) u_shift_out (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (SS_n),
        .load (tx_load),
        .data (tx_data),
        .miso (MISO),
        .done (tx_done)
    );

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

`ifdef SPI_FRAME_ERR_EN
    logic frame_err_q;
    logic abort_err;

    // Abort is an error with a partial word or with the read reply not fully sent.
    assign abort_err = SS_n && (((cnt_q != '0) && (cnt_q != CntFull)) ||
                                ((state_q == READ_DATA) && (cnt_q == CntFull) && !tx_done));

    // One-cycle pulse; the FSM is back in IDLE with a clear counter the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= abort_err;
        end
    end

    assign frame_err = frame_err_q;
`else
    logic unused_tx_done;
    assign unused_tx_done = tx_done;
`endif

endmodule

// File: tb/tb_spi_slave_ram_if.sv
// Directed bench for spi_slave_ram_if with a scoreboard for rx words and MISO bits.
module tb_spi_slave_ram_if;
    import spi_pkg::*;

    logic       clk_tb = 1'b0;
    logic       rst_n;
    logic       mosi;
    logic       ss_n;
    logic       miso;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
`ifdef SPI_FRAME_ERR_EN
    logic       frame_err;
`endif

    int total = 0;
    int bad   = 0;
    int rx_count = 0;
    int n_exp = 0;
    logic [9:0] exp_rx[$];
    logic       exp_miso[$];

    always #5 clk_tb = ~clk_tb;

    spi_slave_ram_if #(
        .ADDR_SIZE(8)
    ) dut (
        .clk      (clk_tb),
        .rst_n    (rst_n),
        .MOSI     (mosi),
        .SS_n     (ss_n),
        .MISO     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
`ifdef SPI_FRAME_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_tb);
        #1;
    endtask

    // Complete frame of 10 bits plus optional trailing bits; SS_n left low.
    task automatic frame(input logic [9:0] w, input int extra);
        exp_rx.push_back(w);
        n_exp++;
        ss_n = 1'b0;
        tick();
        for (int i = 9; i >= 0; i--) begin
            mosi = w[i];
            tick();
        end
        chk("frame_rx_valid", 32'(rx_valid), 32'd1);
        chk("frame_rx_data", 32'(rx_data), 32'(w));
        for (int i = 0; i < extra; i++) begin
            mosi = 1'($urandom_range(0, 1));
            tick();
            chk("extra_no_rx_valid", 32'(rx_valid), 32'd0);
        end
        mosi = 1'b0;
    endtask

    task automatic end_frame();
        ss_n = 1'b1;
        tick();
    endtask

    // Scoreboard monitor: every rx_valid pulse must match the oldest expected word.
    always @(posedge clk_tb) begin
        #1;
        if (rx_valid === 1'b1) begin
            rx_count++;
            if (exp_rx.size() == 0) begin
                chk("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
            end else begin
                chk("rx_scoreboard", 32'(rx_data), 32'(exp_rx.pop_front()));
            end
        end
    end

    initial begin
        logic [7:0] reply;
        rst_n    = 1'b0;
        ss_n     = 1'b1;
        mosi     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        tick();
        tick();
        chk("reset_miso", 32'(miso), 32'd0);
        chk("reset_rx_data", 32'(rx_data), 32'd0);
        chk("reset_rx_valid", 32'(rx_valid), 32'd0);
        chk("reset_state", 32'(dut.state_q), 32'(IDLE));
        chk("reset_rd_seen", 32'(dut.rd_addr_seen_q), 32'd0);
`ifdef SPI_FRAME_ERR_EN
        chk("reset_frame_err", 32'(frame_err), 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Write frame with a stray tx_valid that must be ignored.
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        frame({OP_WR_ADDR, 8'hA5}, 0);
        chk("wr_miso", 32'(miso), 32'd0);
        tick();
        chk("wr_single_pulse", 32'(rx_valid), 32'd0);
        chk("wr_miso_after", 32'(miso), 32'd0);
        chk("wr_rd_seen", 32'(dut.rd_addr_seen_q), 32'd0);
        tx_valid = 1'b0;
        end_frame();
        chk("wr_rx_data_held", 32'(rx_data), 32'h0A5);

        // Read address then read data with an 8'hC3 reply.
        frame({OP_RD_ADDR, 8'hA5}, 0);
        end_frame();
        chk("rda_rd_seen", 32'(dut.rd_addr_seen_q), 32'd1);
        frame({OP_RD_DATA, 8'hC3}, 0);
        chk("rdd_state", 32'(dut.state_q), 32'(READ_DATA));
        chk("rdd_rd_seen_clr", 32'(dut.rd_addr_seen_q), 32'd0);
        tick();
        tick();
        chk("rdd_wait_miso", 32'(miso), 32'd0);
        reply    = 8'hC3;
        tx_data  = reply;
        tx_valid = 1'b1;
        for (int i = 7; i >= 0; i--) exp_miso.push_back(reply[i]);
        exp_miso.push_back(1'b0);
        tick();
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        while (exp_miso.size() != 0) begin
            chk("rdd_miso_bit", 32'(miso), 32'(exp_miso.pop_front()));
            tick();
        end
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();
        chk("rdd_second_reply_ignored", 32'(miso), 32'd0);
        end_frame();
`ifdef SPI_FRAME_ERR_EN
        chk("rdd_no_frame_err", 32'(frame_err), 32'd0);
`endif

        // Read with no prior read address is routed to READ_ADD.
        frame(10'h3FF, 0);
        chk("rd_noaddr_state", 32'(dut.state_q), 32'(READ_ADD));
        end_frame();
        chk("rd_noaddr_seen", 32'(dut.rd_addr_seen_q), 32'd1);

        // Abort after 5 bits.
        ss_n = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            mosi = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
        end
        ss_n = 1'b1;
        tick();
        chk("abort_state", 32'(dut.state_q), 32'(IDLE));
        chk("abort_rx_valid", 32'(rx_valid), 32'd0);
        chk("abort_cnt", 32'(dut.cnt_q), 32'd0);
        chk("abort_rd_seen", 32'(dut.rd_addr_seen_q), 32'd1);
`ifdef SPI_FRAME_ERR_EN
        chk("abort_frame_err", 32'(frame_err), 32'd1);
`endif
        tick();
`ifdef SPI_FRAME_ERR_EN
        chk("abort_frame_err_pulse", 32'(frame_err), 32'd0);
`endif

        // Reset in the middle of the read reply shift.
        frame(10'h355, 0);
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        chk("rst_pre_miso", 32'(miso), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_miso", 32'(miso), 32'd0);
        chk("rst_mid_state", 32'(dut.state_q), 32'(IDLE));
        tick();
        ss_n  = 1'b1;
        rst_n = 1'b1;
        tick();
        chk("rst_rd_seen", 32'(dut.rd_addr_seen_q), 32'd0);

        // Over-long frame: 14 bits, only the first 10 count.
        frame({OP_WR_DATA, 8'hB3}, 4);
        chk("long_rx_data", 32'(rx_data), 32'h1B3);
        end_frame();
        tick();

        chk("rx_pulse_count", 32'(rx_count), 32'(n_exp));
        chk("rx_scoreboard_empty", 32'(exp_rx.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
